// File: rtl/cam_pkg.sv
// Shared types and constants for the camera emulator: FSM/pattern enums,
// register map and power-on timing.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_COLUMN  = 2'd0,
        PAT_ROW     = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_SCROLL  = 2'd3
    } pattern_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_HTIM   = 2'd1;
    localparam logic [1:0] ADDR_VTIM   = 2'd2;
    localparam logic [1:0] ADDR_FRAMES = 2'd3;

    localparam logic [3:0]  DEF_DIV      = 4'd1;
    localparam logic [15:0] DEF_H_ACTIVE = 16'd640;
    localparam logic [15:0] DEF_H_BLANK  = 16'd16;
    localparam logic [15:0] DEF_V_ACTIVE = 16'd480;
    localparam logic [15:0] DEF_V_BLANK  = 16'd4;

    // A programmed zero in any timing or divider field behaves as one.
    function automatic logic [15:0] eff16(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    function automatic logic [3:0] eff4(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

endpackage

// File: rtl/cam_emulator_if.sv
// Register bus between a host (master) and the camera emulator (slave).
interface cam_emulator_if;
    logic [1:0]  er_address;
    logic        er_bus_enable;
    logic        er_rw;
    logic [31:0] er_write_data;
    logic [31:0] er_read_data;
    logic        er_acknowledge;

    modport master (
        output er_address, er_bus_enable, er_rw, er_write_data,
        input  er_read_data, er_acknowledge
    );

    modport slave (
        input  er_address, er_bus_enable, er_rw, er_write_data,
        output er_read_data, er_acknowledge
    );
endinterface

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source; produces black whenever the pixel is not
// inside the active window.
module cam_pattern_gen
    import cam_pkg::*;
(
    input  pattern_t    pattern,
    input  logic [11:0] column,
    input  logic [11:0] row,
    input  logic [11:0] frame,
    input  logic        active,
    output logic [11:0] pixel
);

    always_comb begin
        // NOTE: pixel gets a value before any branch so no path infers a latch.
        pixel = 12'd0;
        if (active) begin
            case (pattern)
                PAT_COLUMN:  pixel = column;
                PAT_ROW:     pixel = row;
                PAT_CHECKER: pixel = {12{column[3] ^ row[3]}};
                PAT_SCROLL:  pixel = column + frame;
                default:     pixel = 12'd0;
            endcase
        end
    end

endmodule

// File: rtl/cam_emulator.sv
// Camera sensor emulator: register-programmed timing generator driving a
// parallel pixel bus with line/frame valids and a frame-done interrupt.
module cam_emulator
    import cam_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    cam_emulator_if.slave  bus,
    output logic           cam_clk,
    output logic [11:0]    cam_pixel,
    output logic           cam_hsync,
    output logic           cam_vsync,
    output logic           er_irq
);

    // Live configuration registers.
    logic        ctrl_enable;
    pattern_t    ctrl_pattern;
    logic        ctrl_irq_en;
    logic [3:0]  ctrl_div;
    logic [31:0] htim;
    logic [31:0] vtim;
    logic [31:0] frames;

    // Shadow copies hold one frame's timing constant while the host rewrites.
    pattern_t    sh_pattern;
    logic        sh_irq_en;
    logic [3:0]  sh_div_m1;
    logic [15:0] sh_ha_m1, sh_hb_m1, sh_va_m1, sh_vb_m1;
    logic [16:0] sh_line_m1;

    logic [3:0]  lat_div_m1;
    logic [15:0] lat_ha_m1, lat_hb_m1, lat_va_m1, lat_vb_m1;
    logic [16:0] lat_line_m1;

    state_t      state, nxt_state;
    logic [16:0] col, nxt_col;
    logic [15:0] row, nxt_row;
    logic [3:0]  div_cnt;
    logic        tick_fall, frame_end, latch_shadow, nxt_active;
    logic [11:0] nxt_pixel;
    logic        accept, frames_wr;
    logic [31:0] rd_mux;

    assign lat_div_m1  = eff4(ctrl_div) - 4'd1;
    assign lat_ha_m1   = eff16(htim[15:0]) - 16'd1;
    assign lat_hb_m1   = eff16(htim[31:16]) - 16'd1;
    assign lat_va_m1   = eff16(vtim[15:0]) - 16'd1;
    assign lat_vb_m1   = eff16(vtim[31:16]) - 16'd1;
    assign lat_line_m1 = {1'b0, eff16(htim[15:0])} + {1'b0, eff16(htim[31:16])} - 17'd1;

    // ---------------------------------------------------------------- bus
    assign accept    = bus.er_bus_enable && !bus.er_acknowledge;
    assign frames_wr = accept && !bus.er_rw && (bus.er_address == ADDR_FRAMES);

    always_comb begin
        case (bus.er_address)
            ADDR_CTRL: rd_mux = {20'd0, ctrl_div, 3'd0, ctrl_irq_en, 1'b0, ctrl_pattern, ctrl_enable};
            ADDR_HTIM: rd_mux = htim;
            ADDR_VTIM: rd_mux = vtim;
            default:   rd_mux = frames;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.er_acknowledge <= 1'b0;
            bus.er_read_data   <= 32'd0;
            ctrl_enable        <= 1'b0;
            ctrl_pattern       <= PAT_COLUMN;
            ctrl_irq_en        <= 1'b0;
            ctrl_div           <= DEF_DIV;
            htim               <= {DEF_H_BLANK, DEF_H_ACTIVE};
            vtim               <= {DEF_V_BLANK, DEF_V_ACTIVE};
        end else begin
            // NOTE: sequential state uses <= so every register sees pre-edge values.
            bus.er_acknowledge <= accept;
            bus.er_read_data   <= (accept && bus.er_rw) ? rd_mux : 32'd0;
            if (accept && !bus.er_rw) begin
                case (bus.er_address)
                    ADDR_CTRL: begin
                        ctrl_enable  <= bus.er_write_data[0];
                        ctrl_pattern <= pattern_t'(bus.er_write_data[2:1]);
                        ctrl_irq_en  <= bus.er_write_data[4];
                        ctrl_div     <= bus.er_write_data[11:8];
                    end
                    ADDR_HTIM: htim <= bus.er_write_data;
                    ADDR_VTIM: vtim <= bus.er_write_data;
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- timing
    assign tick_fall = (state != ST_IDLE) && (div_cnt == sh_div_m1) && cam_clk;

    always_comb begin
        nxt_state = state;
        nxt_col   = col;
        nxt_row   = row;
        frame_end = 1'b0;
        case (state)
            ST_VBLANK: begin
                if (col == sh_line_m1) begin
                    nxt_col = 17'd0;
                    if (row == sh_vb_m1) begin
                        nxt_state = ST_ACTIVE;
                        nxt_row   = 16'd0;
                    end else begin
                        nxt_row = row + 16'd1;
                    end
                end else begin
                    nxt_col = col + 17'd1;
                end
            end
            ST_ACTIVE: begin
                if (col[15:0] == sh_ha_m1) begin
                    nxt_state = ST_HBLANK;
                    nxt_col   = 17'd0;
                end else begin
                    nxt_col = col + 17'd1;
                end
            end
            ST_HBLANK: begin
                if (col[15:0] == sh_hb_m1) begin
                    nxt_col = 17'd0;
                    if (row != sh_va_m1) begin
                        nxt_state = ST_ACTIVE;
                        nxt_row   = row + 16'd1;
                    end else begin
                        frame_end = 1'b1;
                        nxt_state = ctrl_enable ? ST_VBLANK : ST_IDLE;
                        nxt_row   = 16'd0;
                    end
                end else begin
                    nxt_col = col + 17'd1;
                end
            end
            default: ;
        endcase
    end

    assign nxt_active   = (nxt_state == ST_ACTIVE);
    assign latch_shadow = ctrl_enable && ((state == ST_IDLE) || (tick_fall && frame_end));

    cam_pattern_gen u_pattern (
        .pattern (sh_pattern),
        .column  (nxt_col[11:0]),
        .row     (nxt_row[11:0]),
        .frame   (frames[11:0]),
        .active  (nxt_active),
        .pixel   (nxt_pixel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_pattern <= PAT_COLUMN;
            sh_irq_en  <= 1'b0;
            sh_div_m1  <= 4'd0;
            sh_ha_m1   <= 16'd0;
            sh_hb_m1   <= 16'd0;
            sh_va_m1   <= 16'd0;
            sh_vb_m1   <= 16'd0;
            sh_line_m1 <= 17'd0;
        end else if (latch_shadow) begin
            sh_pattern <= ctrl_pattern;
            sh_irq_en  <= ctrl_irq_en;
            sh_div_m1  <= lat_div_m1;
            sh_ha_m1   <= lat_ha_m1;
            sh_hb_m1   <= lat_hb_m1;
            sh_va_m1   <= lat_va_m1;
            sh_vb_m1   <= lat_vb_m1;
            sh_line_m1 <= lat_line_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            col       <= 17'd0;
            row       <= 16'd0;
            div_cnt   <= 4'd0;
            cam_clk   <= 1'b0;
            cam_pixel <= 12'd0;
            cam_hsync <= 1'b0;
            cam_vsync <= 1'b0;
        end else if (state == ST_IDLE) begin
            div_cnt   <= 4'd0;
            cam_clk   <= 1'b0;
            cam_pixel <= 12'd0;
            cam_hsync <= 1'b0;
            cam_vsync <= 1'b0;
            col       <= 17'd0;
            row       <= 16'd0;
            if (ctrl_enable) state <= ST_VBLANK;
        end else if (div_cnt == sh_div_m1) begin
            div_cnt <= 4'd0;
            cam_clk <= ~cam_clk;
            if (cam_clk) begin
                state     <= nxt_state;
                col       <= nxt_col;
                row       <= nxt_row;
                cam_pixel <= nxt_pixel;
                cam_hsync <= nxt_active;
                cam_vsync <= (nxt_state == ST_ACTIVE) || (nxt_state == ST_HBLANK);
            end
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    // An interrupt raised by a frame end beats a simultaneous host clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames <= 32'd0;
            er_irq <= 1'b0;
        end else begin
            if (tick_fall && frame_end) frames <= frames + 32'd1;
            if (tick_fall && frame_end && sh_irq_en) er_irq <= 1'b1;
            else if (frames_wr)                      er_irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_emulator.sv
// Directed-plus-random bench for cam_emulator; expectations come from a
// tick-level frame model built from the programmed timing values.
module tb_cam_emulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cam_clk, cam_hsync, cam_vsync, er_irq;
    logic [11:0] cam_pixel;
    int          tests = 0;
    int          fails = 0;

    logic [13:0] s_tick[$];
    int          s_cyc[$];
    logic [13:0] e_tick[$];
    logic [31:0] rd;

    cam_emulator_if bus();

    cam_emulator dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cam_clk   (cam_clk),
        .cam_pixel (cam_pixel),
        .cam_hsync (cam_hsync),
        .cam_vsync (cam_vsync),
        .er_irq    (er_irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic rw, input logic [1:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        logic got;
        got = 1'b0;
        bus.er_bus_enable = 1'b1;
        bus.er_rw         = rw;
        bus.er_address    = addr;
        bus.er_write_data = wdata;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.er_acknowledge) begin
                got = 1'b1;
                break;
            end
        end
        rdata = bus.er_read_data;
        bus.er_bus_enable = 1'b0;
        check("ack_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'd0, bus.er_acknowledge}, 32'd0);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus_xfer(1'b0, addr, data, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus_xfer(1'b1, addr, 32'd0, v);
        check(tag, v, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {cam_clk, cam_pixel, cam_hsync, cam_vsync, er_irq,
                    bus.er_acknowledge, |bus.er_read_data}, 32'd0);
    endtask

    function automatic logic [11:0] model_pixel(input int pat, input int c, input int r, input int f);
        case (pat)
            0:       return 12'(c % 4096);
            1:       return 12'(r % 4096);
            2:       return (((c / 8) % 2) != ((r / 8) % 2)) ? 12'hFFF : 12'h000;
            default: return 12'((c + f) % 4096);
        endcase
    endfunction

    // One frame as the host sees it: {hsync, vsync, pixel} per pixel-clock tick.
    task automatic build_frame(input int ha, input int hb, input int va, input int vb,
                               input int pat, input int f);
        e_tick.delete();
        for (int i = 0; i < vb * (ha + hb); i++) e_tick.push_back(14'd0);
        for (int r = 0; r < va; r++) begin
            for (int c = 0; c < ha; c++) e_tick.push_back({2'b11, model_pixel(pat, c, r, f)});
            for (int c = 0; c < hb; c++) e_tick.push_back(14'b01_0000_0000_0000);
        end
    endtask

    task automatic collect_ticks(input int n, input int budget);
        logic prev;
        s_tick.delete();
        s_cyc.delete();
        prev = cam_clk;
        for (int cyc = 0; cyc < budget && s_tick.size() < n; cyc++) begin
            @(negedge clk);
            if (cam_clk && !prev) begin
                s_tick.push_back({cam_hsync, cam_vsync, cam_pixel});
                s_cyc.push_back(cyc);
            end
            prev = cam_clk;
        end
        check("tick_count", s_tick.size(), n);
    endtask

    initial begin
        int ha, hb, va, vb, hs_rises, last_hi, k, errs;
        logic prev_h, prev_c;
        logic [11:0] pix4095, pix4096;

        bus.er_bus_enable = 1'b0;
        bus.er_rw         = 1'b0;
        bus.er_address    = 2'd0;
        bus.er_write_data = 32'd0;

        // Reset defaults.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_outputs_zero("reset_outputs");
        rd_check("rst_ctrl",   2'd0, 32'h0000_0100);
        rd_check("rst_htim",   2'd1, 32'h0010_0280);
        rd_check("rst_vtim",   2'd2, 32'h0004_01E0);
        rd_check("rst_frames", 2'd3, 32'h0000_0000);

        // Small frame, div=2, column pattern.
        ha = 4; hb = 2; va = 3; vb = 1;
        wr(2'd1, {16'(hb), 16'(ha)});
        wr(2'd2, {16'(vb), 16'(va)});
        wr(2'd0, 32'h0000_0201);
        build_frame(ha, hb, va, vb, 0, 0);
        collect_ticks(e_tick.size(), 400);
        for (int i = 0; i < s_tick.size() && i < e_tick.size(); i++)
            check($sformatf("s2_tick%0d", i), {18'd0, s_tick[i]}, {18'd0, e_tick[i]});
        if (s_tick.size() >= 24) begin
            check("s2_period_first", s_cyc[1] - s_cyc[0], 32'd4);
            check("s2_period_last",  s_cyc[23] - s_cyc[22], 32'd4);
        end
        repeat (4) @(posedge clk);
        #1;
        rd_check("s2_frames", 2'd3, 32'd1);
        check("s2_irq_masked", {31'd0, er_irq}, 32'd0);

        // Interrupt set and cleared by a FRAMES write.
        do_reset();
        wr(2'd1, 32'h0002_0004);
        wr(2'd2, 32'h0001_0003);
        wr(2'd0, 32'h0000_0211);
        for (int i = 0; i < 400 && !er_irq; i++) begin
            @(posedge clk); #1;
        end
        check("s3_irq_set", {31'd0, er_irq}, 32'd1);
        wr(2'd3, $urandom);
        check("s3_irq_clear", {31'd0, er_irq}, 32'd0);
        rd_check("s3_frames_kept", 2'd3, 32'd1);

        // Disable during row 1: frame completes, then the block idles.
        do_reset();
        wr(2'd1, 32'h0002_0004);
        wr(2'd2, 32'h0001_0003);
        wr(2'd0, 32'h0000_0201);
        hs_rises = 0;
        prev_h   = cam_hsync;
        for (int i = 0; i < 400 && hs_rises < 2; i++) begin
            @(negedge clk);
            if (cam_hsync && !prev_h) hs_rises++;
            prev_h = cam_hsync;
        end
        check("s4_reached_row1", hs_rises, 32'd2);
        wr(2'd0, 32'h0000_0200);
        hs_rises = 0;
        last_hi  = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cam_hsync && !prev_h) hs_rises++;
            if (cam_clk) last_hi = i;
            prev_h = cam_hsync;
        end
        check("s4_last_row_only", hs_rises, 32'd1);
        check("s4_clk_quiet", {31'd0, last_hi < 300}, 32'd1);
        check("s4_syncs_low", {30'd0, cam_hsync, cam_vsync}, 32'd0);
        rd_check("s4_frames", 2'd3, 32'd1);

        // Scroll pattern on a 1x1 frame; the counter carries the pixel through 0xFFF to 0.
        do_reset();
        wr(2'd1, 32'h0000_0000);
        wr(2'd2, 32'h0000_0000);
        wr(2'd0, 32'h0000_0006);
        rd_check("s5_ctrl_div0", 2'd0, 32'h0000_0006);
        rd_check("s5_htim_zero", 2'd1, 32'h0000_0000);
        wr(2'd0, 32'h0000_0007);
        k = 0; errs = 0; pix4095 = 12'h123; pix4096 = 12'h123;
        prev_c = cam_clk;
        for (int i = 0; i < 34000 && k < 4097; i++) begin
            @(negedge clk);
            if (cam_clk && !prev_c && cam_hsync) begin
                if (cam_pixel !== model_pixel(3, 0, 0, k)) errs++;
                if (k == 4095) pix4095 = cam_pixel;
                if (k == 4096) pix4096 = cam_pixel;
                k++;
            end
            prev_c = cam_clk;
        end
        check("s5_active_count", k, 32'd4097);
        check("s5_all_pixels", errs, 32'd0);
        check("s5_pix_4095", {20'd0, pix4095}, 32'h0000_0FFF);
        check("s5_pix_wrap", {20'd0, pix4096}, 32'd0);

        // Reset pulse in the middle of an active line.
        do_reset();
        wr(2'd1, 32'h0002_0004);
        wr(2'd2, 32'h0001_0003);
        wr(2'd0, 32'h0000_0201);
        for (int i = 0; i < 200 && !er_irq && !(cam_vsync === 1'b0 && i > 150); i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 400 && !(cam_hsync && cam_pixel != 12'd0 && i > 120); i++) begin
            @(posedge clk); #1;
        end
        check("s6_in_active", {31'd0, cam_hsync}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_outputs_zero("s6_reset_outputs");
        rd_check("s6_frames", 2'd3, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("s6_stays_idle", {31'd0, cam_clk}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cam_emulator.md
CAM_EMULATOR -- requirements
Module: cam_emulator

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-high: clk  in  1  50MHz main clock; rst  in  1  synchronous active-high reset.
REQ-002 The camera output ports SHALL be: cam_clk  out  1  generated pixel clock; cam_pixel  out  12  pixel data; cam_hsync  out  1  line valid, high during active pixels; cam_vsync  out  1  frame valid, high across all active lines.
REQ-003 The register bus ports SHALL be: er_address  in  2  register select; er_bus_enable  in  1  request; er_rw  in  1  1=read, 0=write; er_write_data  in  32  write data; er_read_data  out  32  read data; er_acknowledge  out  1  one-cycle ack.
REQ-004 The IRQ port SHALL be: er_irq  out  1  frame-done interrupt, level.

Function
REQ-005 Bus handshake: a request SHALL be accepted when er_bus_enable=1 and er_acknowledge=0; er_acknowledge SHALL pulse high for exactly one cycle after the accepting edge; er_read_data SHALL be valid while er_acknowledge=1.
REQ-006 Register 0 (CTRL, R/W) SHALL hold these fields: bit0 enable; bits2:1 pattern; bit4 irq_enable; bits11:8 div (0 read back as stored, used as 1).
REQ-007 Register 1 (HTIM, R/W) SHALL hold h_active in bits15:0 and h_blank in bits31:16.
REQ-008 Register 2 (VTIM, R/W) SHALL hold v_active in bits15:0 and v_blank in bits31:16.
REQ-009 Register 3 (FRAMES) SHALL read as the 32-bit frame counter; any write to it SHALL clear er_irq and leave the counter unchanged.
REQ-010 In all four timing fields, a value of 0 SHALL be treated as 1.
REQ-011 Pixel tick: cam_clk SHALL toggle every div clk cycles while not IDLE, giving a period of 2*div.
REQ-012 cam_pixel, cam_hsync and cam_vsync SHALL update only on the clk edge where cam_clk goes 1->0, so they are stable across every rising cam_clk edge.
REQ-013 The FSM SHALL have the states IDLE, VBLANK, ACTIVE and HBLANK.
REQ-014 IDLE: cam_clk SHALL be held 0 with all outputs 0; when enable=1, the FSM SHALL latch CTRL/HTIM/VTIM into shadow registers and go to VBLANK.
REQ-015 VBLANK SHALL last v_blank*(h_active+h_blank) ticks with both syncs 0, then go to ACTIVE with row=0.
REQ-016 ACTIVE SHALL last h_active ticks with cam_hsync=1, cam_vsync=1 and the column counting 0..h_active-1, then go to HBLANK.
REQ-017 HBLANK SHALL last h_blank ticks with cam_hsync=0 and cam_vsync=1; if row<v_active-1 it SHALL increment row and go to ACTIVE, otherwise the frame ends.
REQ-018 Frame end: the frame counter SHALL increment (wrapping modulo 2^32) and cam_vsync SHALL fall on the same tick; er_irq SHALL be set if irq_enable=1.
REQ-019 After frame end, if enable=1 the FSM SHALL re-latch the shadows and go to VBLANK; otherwise it SHALL go to IDLE.
REQ-020 Clearing enable mid-frame SHALL complete the current frame; register writes mid-frame SHALL take effect only at the next shadow latch.
REQ-021 Patterns SHALL be computed from the 12-bit truncation of: 0 column; 1 row; 2 {12{column[3]^row[3]}}; 3 column+frame_counter[11:0].
REQ-022 cam_pixel SHALL be 0 outside ACTIVE.
REQ-023 If the IRQ set and an FRAMES write occur in the same cycle, the set SHALL win.

Reset
REQ-024 On rst=1 at a clk edge: the FSM SHALL enter IDLE; cam_clk, cam_pixel, cam_hsync, cam_vsync, er_acknowledge, er_irq and er_read_data SHALL be 0; the frame counter SHALL be 0.
REQ-025 The reset values of the configuration registers SHALL be CTRL=0x00000100 (div=1, disabled), HTIM={16,640} and VTIM={4,480}.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with no counter increment and no IRQ.

Structure
REQ-027 A shared package cam_pkg SHALL hold the FSM state enum, the pattern enum, the register address constants and the default timing constants.
REQ-028 One sub-module, cam_pattern_gen, SHALL implement REQ-021 and REQ-022 combinationally from (pattern, column, row, frame, active).

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then read all 4 registers -> 0x100, 0x00100280, 0x000401E0, 0; each ack exactly 1 cycle.
- div=2, HTIM={2,4}, VTIM={1,3}, pattern 0, enable -> cam_clk period 4 clk; per line hsync high 4 ticks with pixels 0,1,2,3, then low 2; vsync high 18 ticks after a 6-tick vblank; FRAMES=1 after the first frame.
- irq_enable=1, one frame done -> er_irq=1; write FRAMES -> er_irq=0 next cycle, counter unchanged.
- Clear enable at row 1 of 3 -> the frame completes, counter increments, FSM goes to IDLE, and cam_clk stays 0.
- Pattern 3 with counter preset via 4096 short frames (h=v=1) -> the column-0 pixel wraps to 0.
- rst pulsed during ACTIVE -> all outputs 0 the next cycle and FRAMES=0.
